// File: rtl/lab71_2_led_fader_pkg.sv
// lab71_2_led_fader_pkg: shared intensity constants, level type and ramp step helper
package lab71_2_led_fader_pkg;
  localparam int LEVEL_BITS = 4;
  localparam int LEVEL_MAX = 2**LEVEL_BITS - 1;
  typedef logic [LEVEL_BITS-1:0] level_t;
  function automatic level_t step_toward(level_t level, level_t target);
    return level < target ? level + 1'b1 : level > target ? level - 1'b1 : level;
  endfunction
endpackage

// File: rtl/lab71_2_led_fade_channel.sv
// lab71_2_led_fade_channel: one LED's intensity ramp and PWM compare
//   clk, reset_n   clock and asynchronous active-low reset
//   target_bit     pattern bit; selects full-on or full-off target level
//   enable         1 = ramp on tick, 0 = snap to target
//   tick           one-cycle ramp step strobe
//   pwm_cnt        shared PWM phase, 0..LEVEL_MAX-1
//   led            registered PWM drive
//   mismatch       level differs from target (feeds the busy reduce)
module lab71_2_led_fade_channel
  import lab71_2_led_fader_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  target_bit,
  input  logic                  enable,
  input  logic                  tick,
  input  logic [LEVEL_BITS-1:0] pwm_cnt,
  output logic                  led,
  output logic                  mismatch
);
  level_t level_q, level_d, target;
  logic led_q, led_d;
  always_comb begin
    target = target_bit ? level_t'(LEVEL_MAX) : '0;
    level_d = !enable ? target : tick ? step_toward(level_q, target) : level_q;
    led_d = level_q > pwm_cnt;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= '0;
      led_q <= 1'b0;
    end else begin
      level_q <= level_d;
      led_q <= led_d;
    end
  end
  assign led = led_q;
  assign mismatch = level_q != target;
endmodule

// File: rtl/lab71_2_led_fader.sv
// lab71_2_led_fader: per-LED fade-in/fade-out of the PIO pattern with shared PWM
//   clk, reset_n   clock and asynchronous active-low reset
//   pattern        LED pattern from the PIO out_port
//   enable         1 = fade mode, 0 = bypass (LEDs track pattern)
//   leds           registered PWM LED drive, 1 = lit
//   busy           registered; 1 while any channel is still ramping
module lab71_2_led_fader
  import lab71_2_led_fader_pkg::*;
#(
  parameter int WIDTH = 14,
  parameter int TICK_DIV = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pattern,
  input  logic             enable,
  output logic [WIDTH-1:0] leds,
  output logic             busy
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  logic [WIDTH-1:0] pattern_q, pattern_d, mismatch, led_w;
  logic [PW-1:0] presc_q, presc_d;
  logic tick_q, tick_d, busy_q, busy_d;
  level_t pwm_q, pwm_d;
  always_comb begin
    pattern_d = pattern;
    presc_d = (!enable || presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
    tick_d = enable && presc_q == PRESC_LAST;
    pwm_d = pwm_q == level_t'(LEVEL_MAX - 1) ? '0 : pwm_q + 1'b1;
    busy_d = |mismatch;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pattern_q <= '0;
      presc_q <= '0;
      tick_q <= 1'b0;
      pwm_q <= '0;
      busy_q <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      presc_q <= presc_d;
      tick_q <= tick_d;
      pwm_q <= pwm_d;
      busy_q <= busy_d;
    end
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    lab71_2_led_fade_channel u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .target_bit (pattern_q[i]),
      .enable     (enable),
      .tick       (tick_q),
      .pwm_cnt    (pwm_q),
      .led        (led_w[i]),
      .mismatch   (mismatch[i])
    );
  end
  assign leds = led_w;
  assign busy = busy_q;
endmodule
